// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator for the pipelined RISC-V core.
// Holds the PC at the reset vector through a short start-up window, then
// steps sequentially, honours an N-way stall and three prioritised redirect
// sources (trap > ret > branch). A redirect raised while stalled is parked
// in a one-entry pending buffer and applied when the stall releases.
module pc_gen #(
  parameter int unsigned          ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = {ADDR_W{1'b0}},
  parameter int unsigned          STALL_N      = 3,
  parameter int unsigned          INIT_CYCLES  = 1,
  parameter int unsigned          ALIGN_BITS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_N-1:0] stall_i,
  input  logic               br_valid_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  input  logic               ret_valid_i,
  input  logic [ADDR_W-1:0]  ret_target_i,
  input  logic               trap_valid_i,
  input  logic [ADDR_W-1:0]  trap_target_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               pc_valid_o,
  output logic               redirect_o,
  output logic               misalign_o
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_STEP    = ONE << ALIGN_BITS;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(PC_STEP - ONE);
  localparam logic [3:0]        INIT_LAST  = 4'(INIT_CYCLES);

  // Priority codes; 0 means "no request" so any real request beats an empty buffer.
  localparam logic [1:0] PRIO_NONE = 2'd0;
  localparam logic [1:0] PRIO_BR   = 2'd1;
  localparam logic [1:0] PRIO_RET  = 2'd2;
  localparam logic [1:0] PRIO_TRAP = 2'd3;

  // Clear the low alignment bits of a redirect target.
  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] t);
    return t & ALIGN_MASK;
  endfunction

  // Flag a target whose low alignment bits are not all zero.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] t);
    return |(t & ~ALIGN_MASK);
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic                pc_valid_r, pc_valid_s;
  logic                redirect_r, redirect_s;
  logic                misalign_r, misalign_s;
  logic [3:0]          init_cnt_r, init_cnt_s;
  logic [ADDR_W-1:0]   pend_target_r, pend_target_s;
  logic [1:0]          pend_prio_r, pend_prio_s;
  logic                pend_mis_r, pend_mis_s;

  logic                stall_s;
  logic                req_valid_s;
  logic [1:0]          req_prio_s;
  logic [ADDR_W-1:0]   req_target_s;
  logic                req_mis_s;
  logic                take_new_s;
  logic [ADDR_W-1:0]   win_target_s;
  logic [1:0]          win_prio_s;
  logic                win_mis_s;

  assign stall_s = |stall_i;

  // Pick this cycle's winning new request (trap > ret > branch) and align it.
  always_comb begin
    req_valid_s  = 1'b0;
    req_prio_s   = PRIO_NONE;
    req_target_s = {ADDR_W{1'b0}};
    req_mis_s    = 1'b0;
    if (trap_valid_i) begin
      req_valid_s  = 1'b1;
      req_prio_s   = PRIO_TRAP;
      req_target_s = align_target(trap_target_i);
      req_mis_s    = is_misaligned(trap_target_i);
    end else if (ret_valid_i) begin
      req_valid_s  = 1'b1;
      req_prio_s   = PRIO_RET;
      req_target_s = align_target(ret_target_i);
      req_mis_s    = is_misaligned(ret_target_i);
    end else if (br_valid_i) begin
      req_valid_s  = 1'b1;
      req_prio_s   = PRIO_BR;
      req_target_s = align_target(br_target_i);
      req_mis_s    = is_misaligned(br_target_i);
    end else begin
      req_valid_s  = 1'b0;
    end
  end

  // Merge new request with the pending one; equal priority favours the newer request.
  always_comb begin
    take_new_s = req_valid_s && (req_prio_s >= pend_prio_r);
    if (take_new_s) begin
      win_target_s = req_target_s;
      win_prio_s   = req_prio_s;
      win_mis_s    = req_mis_s;
    end else begin
      win_target_s = pend_target_r;
      win_prio_s   = pend_prio_r;
      win_mis_s    = pend_mis_r;
    end
  end

  // Next-state and next-output logic for the INIT / RUN / HOLD sequencer.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pc_valid_s    = pc_valid_r;
    redirect_s    = 1'b0;
    misalign_s    = 1'b0;
    init_cnt_s    = init_cnt_r;
    pend_target_s = pend_target_r;
    pend_prio_s   = pend_prio_r;
    pend_mis_s    = pend_mis_r;
    case (state_r)
      ST_INIT: begin
        init_cnt_s = init_cnt_r + 4'd1;
        if ((init_cnt_r + 4'd1) == INIT_LAST) begin
          state_s    = ST_RUN;
          pc_valid_s = 1'b1;
        end else begin
          state_s    = ST_INIT;
          pc_valid_s = 1'b0;
        end
      end
      ST_RUN: begin
        pc_valid_s = 1'b1;
        if (!stall_s) begin
          if (req_valid_s) begin
            pc_s       = req_target_s;
            redirect_s = 1'b1;
            misalign_s = req_mis_s;
          end else begin
            pc_s = pc_r + PC_STEP;
          end
        end else if (req_valid_s) begin
          pend_target_s = req_target_s;
          pend_prio_s   = req_prio_s;
          pend_mis_s    = req_mis_s;
          state_s       = ST_HOLD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        pc_valid_s = 1'b1;
        if (stall_s) begin
          pend_target_s = win_target_s;
          pend_prio_s   = win_prio_s;
          pend_mis_s    = win_mis_s;
        end else begin
          pc_s          = win_target_s;
          redirect_s    = 1'b1;
          misalign_s    = win_mis_s;
          pend_target_s = {ADDR_W{1'b0}};
          pend_prio_s   = PRIO_NONE;
          pend_mis_s    = 1'b0;
          state_s       = ST_RUN;
        end
      end
      default: begin
        state_s       = ST_INIT;
        pc_s          = RESET_VECTOR;
        pc_valid_s    = 1'b0;
        init_cnt_s    = 4'd0;
        pend_target_s = {ADDR_W{1'b0}};
        pend_prio_s   = PRIO_NONE;
        pend_mis_s    = 1'b0;
      end
    endcase
  end

  // State, PC, pending buffer and output pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_INIT;
      pc_r          <= RESET_VECTOR;
      pc_valid_r    <= 1'b0;
      redirect_r    <= 1'b0;
      misalign_r    <= 1'b0;
      init_cnt_r    <= 4'd0;
      pend_target_r <= {ADDR_W{1'b0}};
      pend_prio_r   <= PRIO_NONE;
      pend_mis_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      pc_valid_r    <= pc_valid_s;
      redirect_r    <= redirect_s;
      misalign_r    <= misalign_s;
      init_cnt_r    <= init_cnt_s;
      pend_target_r <= pend_target_s;
      pend_prio_r   <= pend_prio_s;
      pend_mis_r    <= pend_mis_s;
    end
  end

  assign pc_o       = pc_r;
  assign pc_valid_o = pc_valid_r;
  assign redirect_o = redirect_r;
  assign misalign_o = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed stimulus, a cycle-level reference model
// compared every cycle, and hand-computed literal expectations.
module tb_pc_gen;

  localparam int INIT_N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  stall = 3'b000;
  logic        br_v = 1'b0, ret_v = 1'b0, trap_v = 1'b0;
  logic [31:0] br_t = 32'h0, ret_t = 32'h0, trap_t = 32'h0;
  logic [31:0] pc;
  logic        pc_valid, redirect, misalign;

  logic [2:0]  stall16 = 3'b100;
  logic [15:0] zero16 = 16'h0;
  logic [15:0] pc16;
  logic        valid16, redir16, mis16;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_valid, m_redir, m_mis;
  int          m_since;
  logic        m_pend_v;
  logic [31:0] m_pend_t;
  int          m_pend_p;
  logic [15:0] m16_pc;
  logic        m16_valid;
  int          m16_since;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h100), .STALL_N(3),
           .INIT_CYCLES(INIT_N), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .br_valid_i(br_v), .br_target_i(br_t),
    .ret_valid_i(ret_v), .ret_target_i(ret_t),
    .trap_valid_i(trap_v), .trap_target_i(trap_t),
    .pc_o(pc), .pc_valid_o(pc_valid), .redirect_o(redirect), .misalign_o(misalign));

  pc_gen #(.ADDR_W(16), .RESET_VECTOR(16'hFFF8), .STALL_N(3),
           .INIT_CYCLES(1), .ALIGN_BITS(2)) dut16 (
    .clk(clk), .rst(rst), .stall_i(stall16),
    .br_valid_i(1'b0), .br_target_i(zero16),
    .ret_valid_i(1'b0), .ret_target_i(zero16),
    .trap_valid_i(1'b0), .trap_target_i(zero16),
    .pc_o(pc16), .pc_valid_o(valid16), .redirect_o(redir16), .misalign_o(mis16));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per clock edge, or reset when rst is low.
  task automatic model_step();
    int np;
    logic [31:0] nt;
    logic have;
    logic [31:0] ct;
    int cp;
    if (!rst) begin
      m_pc = 32'h100; m_valid = 1'b0; m_redir = 1'b0; m_mis = 1'b0;
      m_since = 0; m_pend_v = 1'b0; m_pend_t = 32'h0; m_pend_p = 0;
      m16_pc = 16'hFFF8; m16_valid = 1'b0; m16_since = 0;
    end else begin
      np = 0; nt = 32'h0;
      if (trap_v) begin np = 3; nt = trap_t; end
      else if (ret_v) begin np = 2; nt = ret_t; end
      else if (br_v) begin np = 1; nt = br_t; end
      m_redir = 1'b0; m_mis = 1'b0;
      if (m_since < INIT_N) begin
        m_since++;
        m_valid = (m_since == INIT_N);
      end else begin
        have = m_pend_v; ct = m_pend_t; cp = m_pend_p;
        if (np > 0 && (!have || np >= cp)) begin have = 1'b1; ct = nt; cp = np; end
        if (stall != 3'b000) begin
          m_pend_v = have; m_pend_t = ct; m_pend_p = cp;
        end else if (have) begin
          m_pc = ct & ~32'h3;
          m_redir = 1'b1;
          m_mis = (ct[1:0] != 2'b00);
          m_pend_v = 1'b0; m_pend_p = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      if (m16_since < 1) begin
        m16_since++;
        m16_valid = 1'b1;
      end else if (stall16 == 3'b000) begin
        m16_pc = m16_pc + 16'd4;
      end
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("pc", pc, m_pc);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
      chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
      chk("pc16", {16'd0, pc16}, {16'd0, m16_pc});
      chk("valid16", {31'd0, valid16}, {31'd0, m16_valid});
      chk("redir16", {31'd0, redir16}, {31'd0, 1'b0});
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin
    // 1. reset and start-up
    tick(); tick();
    chk("rst_pc", pc, 32'h100);
    rst = 1'b1;
    chk("init_valid_a", {31'd0, pc_valid}, 32'd0);
    tick();
    chk("init_valid_b", {31'd0, pc_valid}, 32'd0);
    chk("init_pc", pc, 32'h100);
    tick();
    chk("run_valid", {31'd0, pc_valid}, 32'd1);
    chk("run_pc0", pc, 32'h100);
    tick(); chk("run_pc1", pc, 32'h104);
    tick(); chk("run_pc2", pc, 32'h108);
    tick(); tick(); chk("run_pc4", pc, 32'h110);

    // 2. branch, no stall
    br_v = 1'b1; br_t = 32'h2000;
    tick(); br_v = 1'b0;
    chk("br_pc", pc, 32'h2000);
    chk("br_redir", {31'd0, redirect}, 32'd1);
    tick();
    chk("br_next", pc, 32'h2004);
    chk("br_redir_off", {31'd0, redirect}, 32'd0);

    // 3. branch during a 4-cycle stall
    stall = 3'b010;
    tick(); chk("st_c1", pc, 32'h2004);
    br_v = 1'b1; br_t = 32'h3000;
    tick(); br_v = 1'b0; chk("st_c2", pc, 32'h2004);
    tick(); chk("st_c3", pc, 32'h2004);
    tick(); chk("st_c4", pc, 32'h2004);
    chk("st_no_pulse", {31'd0, redirect}, 32'd0);
    stall = 3'b000;
    tick();
    chk("st_rel_pc", pc, 32'h3000);
    chk("st_rel_redir", {31'd0, redirect}, 32'd1);
    tick(); chk("st_rel_next", pc, 32'h3004);

    // 4. priority while stalled; ret after trap is dropped
    stall = 3'b010;
    br_v = 1'b1; br_t = 32'h3000;
    tick(); br_v = 1'b0; trap_v = 1'b1; trap_t = 32'h8000;
    tick(); trap_v = 1'b0; ret_v = 1'b1; ret_t = 32'h5000;
    tick(); ret_v = 1'b0;
    chk("pr_hold", pc, 32'h3004);
    stall = 3'b000;
    tick();
    chk("pr_pc", pc, 32'h8000);
    chk("pr_redir", {31'd0, redirect}, 32'd1);
    // same-cycle trap + br unstalled
    trap_v = 1'b1; trap_t = 32'h9000; br_v = 1'b1; br_t = 32'h4000;
    tick(); trap_v = 1'b0; br_v = 1'b0;
    chk("tb_pc", pc, 32'h9000);
    chk("tb_redir", {31'd0, redirect}, 32'd1);
    tick(); chk("tb_next", pc, 32'h9004);

    // 5. misaligned target
    br_v = 1'b1; br_t = 32'h2002;
    tick(); br_v = 1'b0;
    chk("mis_pc", pc, 32'h2000);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_redir", {31'd0, redirect}, 32'd1);
    tick();
    chk("mis_next", pc, 32'h2004);
    chk("mis_off", {31'd0, misalign}, 32'd0);

    // back-to-back redirects and same-priority replacement while stalled
    br_v = 1'b1; br_t = 32'h1000;
    tick(); br_t = 32'h1100;
    tick(); br_v = 1'b0;
    chk("b2b_pc", pc, 32'h1100);
    chk("b2b_redir", {31'd0, redirect}, 32'd1);
    stall = 3'b001;
    br_v = 1'b1; br_t = 32'h600;
    tick(); br_t = 32'h700;
    tick(); br_v = 1'b0; stall = 3'b000;
    tick();
    chk("same_prio_pc", pc, 32'h700);

    // 6. wrap-around on the 16-bit instance
    chk("wrap_hold", {16'd0, pc16}, 32'h0000FFF8);
    stall16 = 3'b000;
    tick(); chk("wrap_fffc", {16'd0, pc16}, 32'h0000FFFC);
    tick(); chk("wrap_zero", {16'd0, pc16}, 32'h00000000);
    tick(); chk("wrap_four", {16'd0, pc16}, 32'h00000004);
    stall16 = 3'b100;

    // reset mid-run aborts a pending redirect
    stall = 3'b100;
    br_v = 1'b1; br_t = 32'hA000;
    tick(); br_v = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h100);
    chk("arst_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    stall = 3'b000;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("rerun_pc", pc, 32'h100);
    chk("rerun_redir", {31'd0, redirect}, 32'd0);
    tick();
    chk("rerun_next", pc, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
